// File: rtl/pifo_task_pkg.sv
// rtl/pifo_task_pkg.sv - shared op encoding, issuer state enum and tree-id width helper
package pifo_task_pkg;

    localparam logic OP_POP  = 1'b0;
    localparam logic OP_PUSH = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_DRAIN
    } state_e;

    // A single-tree build still needs a one-bit tree-id port.
    function automatic int tidw(input int tree_num);
        return (tree_num <= 1) ? 1 : $clog2(tree_num);
    endfunction

endpackage

// File: rtl/pifo_rsp_fifo.sv
// rtl/pifo_rsp_fifo.sv - first-word-fall-through response buffer with occupancy count
module pifo_rsp_fifo #(
    parameter int DW    = 18,
    parameter int DEPTH = 4,
    localparam int AW   = (DEPTH <= 2) ? 1 : $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_wr_valid,
    input  logic [DW-1:0] i_wr_data,
    output logic          o_rd_valid,
    input  logic          i_rd_ready,
    output logic [DW-1:0] o_rd_data,
    output logic [CW-1:0] o_count
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          rd_en;
    logic          wr_en;

    // A write into a full buffer is only taken when a read frees a slot in the same cycle.
    always_comb begin
        rd_en    = i_rd_ready && (count_q != '0);
        wr_en    = i_wr_valid && ((count_q != DEPTH_C) || rd_en);
        wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(wr_en) - CW'(rd_en);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= i_wr_data;
        end
    end

    assign o_rd_valid = (count_q != '0);
    assign o_rd_data  = o_rd_valid ? mem_q[rd_ptr_q] : '0;
    assign o_count    = count_q;

endmodule

// File: rtl/pifo_task_issuer.sv
// rtl/pifo_task_issuer.sv - PIFO lane push/pop issuer with response buffer; PIFO_ISSUE_STATS_EN adds issue counters
module pifo_task_issuer
    import pifo_task_pkg::*;
#(
    parameter int PTW       = 16,
    parameter int MTW       = 0,
    parameter int TREE_NUM  = 4,
    parameter int RSP_DEPTH = 4,
    localparam int TIDW     = tidw(TREE_NUM),
    localparam int DW       = MTW + PTW,
    localparam int CW       = $clog2(RSP_DEPTH) + 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_cmd_valid,
    output logic            o_cmd_ready,
    input  logic            i_cmd_op,
    input  logic [TIDW-1:0] i_cmd_tree_id,
    input  logic [DW-1:0]   i_cmd_data,
    input  logic            i_flush,
    output logic            o_flush_done,
    output logic            o_push,
    output logic            o_pop,
    output logic [TIDW-1:0] o_tree_id,
    output logic [DW-1:0]   o_push_data,
    input  logic            i_task_fifo_full,
    input  logic            i_is_level0_pop,
    input  logic [TIDW-1:0] i_pop_tree_id,
    input  logic [DW-1:0]   i_pop_data,
    output logic            o_rsp_valid,
    input  logic            i_rsp_ready,
    output logic [TIDW-1:0] o_rsp_tree_id,
    output logic [DW-1:0]   o_rsp_data,
    output logic            o_rsp_empty,
    output logic [CW-1:0]   o_outstanding,
    output logic            o_err_spurious
`ifdef PIFO_ISSUE_STATS_EN
    ,
    output logic [31:0]     o_stat_push,
    output logic [31:0]     o_stat_pop,
    output logic [31:0]     o_stat_stall
`endif
);

    localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);

    state_e          state_q, state_d;
    logic            hold_op_q;
    logic [TIDW-1:0] hold_tid_q;
    logic [DW-1:0]   hold_data_q;
    logic [CW-1:0]   out_q, out_d;
    logic            err_q;
    logic            cmd_ready;
    logic            load;
    logic            issue_ok;
    logic            push;
    logic            pop;
    logic            flush_done;
    logic            capture;
    logic            stall;
    logic            fifo_valid;
    logic [CW-1:0]   fifo_count;

    always_comb begin
        state_d    = state_q;
        cmd_ready  = 1'b0;
        load       = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        stall      = 1'b0;
        flush_done = 1'b0;
        issue_ok   = !i_task_fifo_full && ((hold_op_q == OP_PUSH) || (out_q < DEPTH_C));
        case (state_q)
            S_IDLE: begin
                cmd_ready = !i_flush;
                if (i_cmd_valid && cmd_ready) begin
                    load    = 1'b1;
                    state_d = S_HOLD;
                end else if (i_flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_HOLD: begin
                if (issue_ok) begin
                    push      = (hold_op_q == OP_PUSH);
                    pop       = (hold_op_q == OP_POP);
                    cmd_ready = !i_flush;
                    if (i_cmd_valid && cmd_ready) begin
                        load = 1'b1;
                    end else if (i_flush) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    stall = 1'b1;
                end
            end
            S_DRAIN: begin
                flush_done = i_flush && (out_q == '0) && !fifo_valid;
                if (!i_flush) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Results only count against issued pops; anything else is flagged and dropped.
    always_comb begin
        capture = i_is_level0_pop && (out_q != '0);
        out_d   = out_q + CW'(pop) - CW'(capture);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            hold_op_q   <= OP_POP;
            hold_tid_q  <= '0;
            hold_data_q <= '1;
            out_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            if (load) begin
                hold_op_q   <= i_cmd_op;
                hold_tid_q  <= i_cmd_tree_id;
                hold_data_q <= (i_cmd_op == OP_PUSH) ? i_cmd_data : '0;
            end
            if (i_is_level0_pop && (out_q == '0)) begin
                err_q <= 1'b1;
            end
        end
    end

    pifo_rsp_fifo #(
        .DW    (TIDW + DW),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_wr_valid (capture),
        .i_wr_data  ({i_pop_tree_id, i_pop_data}),
        .o_rd_valid (fifo_valid),
        .i_rd_ready (i_rsp_ready),
        .o_rd_data  ({o_rsp_tree_id, o_rsp_data}),
        .o_count    (fifo_count)
    );

    assign o_cmd_ready    = cmd_ready && !i_rst;
    assign o_flush_done   = flush_done;
    assign o_push         = push;
    assign o_pop          = pop;
    assign o_tree_id      = hold_tid_q;
    assign o_push_data    = hold_data_q;
    assign o_rsp_valid    = fifo_valid;
    assign o_rsp_empty    = (o_rsp_data == '1);
    assign o_outstanding  = out_q;
    assign o_err_spurious = err_q;

`ifdef PIFO_ISSUE_STATS_EN
    logic [31:0] stat_push_q, stat_pop_q, stat_stall_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stat_push_q  <= '0;
            stat_pop_q   <= '0;
            stat_stall_q <= '0;
        end else begin
            if (push && (stat_push_q != '1)) stat_push_q <= stat_push_q + 32'd1;
            if (pop && (stat_pop_q != '1)) stat_pop_q <= stat_pop_q + 32'd1;
            if (stall && (stat_stall_q != '1)) stat_stall_q <= stat_stall_q + 32'd1;
        end
    end

    assign o_stat_push  = stat_push_q;
    assign o_stat_pop   = stat_pop_q;
    assign o_stat_stall = stat_stall_q;
`else
    logic unused_count;
    assign unused_count = ^fifo_count;
`endif

endmodule

// File: tb/tb_pifo_task_issuer.sv
// tb/tb_pifo_task_issuer.sv - directed self-checking bench for pifo_task_issuer
module tb_pifo_task_issuer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_op;
    logic [1:0]  cmd_tid;
    logic [15:0] cmd_data;
    logic        flush, flush_done;
    logic        push, pop;
    logic [1:0]  tree_id;
    logic [15:0] push_data;
    logic        full;
    logic        l0_pop;
    logic [1:0]  pop_tid;
    logic [15:0] pop_data;
    logic        rsp_valid, rsp_ready;
    logic [1:0]  rsp_tid;
    logic [15:0] rsp_data;
    logic        rsp_empty;
    logic [2:0]  outstanding;
    logic        err;
`ifdef PIFO_ISSUE_STATS_EN
    logic [31:0] stat_push, stat_pop, stat_stall;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pifo_task_issuer dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_cmd_valid      (cmd_valid),
        .o_cmd_ready      (cmd_ready),
        .i_cmd_op         (cmd_op),
        .i_cmd_tree_id    (cmd_tid),
        .i_cmd_data       (cmd_data),
        .i_flush          (flush),
        .o_flush_done     (flush_done),
        .o_push           (push),
        .o_pop            (pop),
        .o_tree_id        (tree_id),
        .o_push_data      (push_data),
        .i_task_fifo_full (full),
        .i_is_level0_pop  (l0_pop),
        .i_pop_tree_id    (pop_tid),
        .i_pop_data       (pop_data),
        .o_rsp_valid      (rsp_valid),
        .i_rsp_ready      (rsp_ready),
        .o_rsp_tree_id    (rsp_tid),
        .o_rsp_data       (rsp_data),
        .o_rsp_empty      (rsp_empty),
        .o_outstanding    (outstanding),
        .o_err_spurious   (err)
`ifdef PIFO_ISSUE_STATS_EN
        ,
        .o_stat_push      (stat_push),
        .o_stat_pop       (stat_pop),
        .o_stat_stall     (stat_stall)
`endif
    );

    // Push and pop together would be a silent no-op at the lane.
    always @(negedge clk) begin
        if (!rst) begin
            n_cmp++;
            if (push && pop) begin n_fail++; $display("FAIL push_pop_exclusive: push=%0b pop=%0b required not both", push, pop); end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        #1;
        n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_ready: got %0b want 0", cmd_ready); end
        n_cmp++; if (push !== 1'b0 || pop !== 1'b0) begin n_fail++; $display("FAIL rst_push_pop: got %0b%0b want 00", push, pop); end
        n_cmp++; if (tree_id !== 2'd0) begin n_fail++; $display("FAIL rst_tree_id: got %0h want 0", tree_id); end
        n_cmp++; if (push_data !== 16'hFFFF) begin n_fail++; $display("FAIL rst_push_data: got %h want ffff", push_data); end
        n_cmp++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL rst_outstanding: got %0d want 0", outstanding); end
        n_cmp++; if (rsp_valid !== 1'b0 || rsp_data !== 16'h0 || rsp_tid !== 2'd0 || rsp_empty !== 1'b0) begin
            n_fail++; $display("FAIL rst_rsp: got v=%0b d=%h t=%0h e=%0b want 0/0000/0/0", rsp_valid, rsp_data, rsp_tid, rsp_empty); end
        n_cmp++; if (err !== 1'b0 || flush_done !== 1'b0) begin n_fail++; $display("FAIL rst_err_flush: got %0b%0b want 00", err, flush_done); end
        rst = 1'b0;
        #1;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready: got %0b want 1", cmd_ready); end
    endtask

    task automatic test_push();
        tick();
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_tid = 2'd2; cmd_data = 16'h00A5;
        tick();
        cmd_valid = 1'b0;
        #1;
        n_cmp++; if (push !== 1'b1 || pop !== 1'b0) begin n_fail++; $display("FAIL push_issue: got push=%0b pop=%0b want 1 0", push, pop); end
        n_cmp++; if (tree_id !== 2'd2 || push_data !== 16'h00A5) begin n_fail++; $display("FAIL push_fields: got %0h/%h want 2/00a5", tree_id, push_data); end
        tick();
        n_cmp++; if (push !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL push_idle: got push=%0b ready=%0b want 0 1", push, cmd_ready); end
    endtask

    task automatic test_stall();
        tick();
        full = 1'b1;
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_tid = 2'd1; cmd_data = 16'h1234;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (push !== 1'b0 || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL stall_%0d: got push=%0b ready=%0b want 0 0", i, push, cmd_ready); end
            n_cmp++; if (tree_id !== 2'd1 || push_data !== 16'h1234) begin n_fail++; $display("FAIL stall_hold_%0d: got %0h/%h want 1/1234", i, tree_id, push_data); end
            tick();
        end
        full = 1'b0;
        #1;
        n_cmp++; if (push !== 1'b1 || push_data !== 16'h1234) begin n_fail++; $display("FAIL stall_release: got push=%0b d=%h want 1 1234", push, push_data); end
        tick();
        n_cmp++; if (push !== 1'b0) begin n_fail++; $display("FAIL stall_after: got %0b want 0", push); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) begin
            tick();
            cmd_valid = 1'b1; cmd_op = 1'b0; cmd_tid = 2'(i); cmd_data = 16'hBEEF;
            #1;
            if (i > 0) begin
                n_cmp++; if (pop !== 1'b1 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_pop_%0d: got pop=%0b ready=%0b want 1 1", i, pop, cmd_ready); end
                n_cmp++; if (push_data !== 16'h0 || tree_id !== 2'(i - 1)) begin n_fail++; $display("FAIL b2b_fields_%0d: got %h/%0h want 0000/%0h", i, push_data, tree_id, i - 1); end
            end
        end
        tick();
        cmd_valid = 1'b0;
        #1;
        n_cmp++; if (pop !== 1'b0 || cmd_ready !== 1'b0 || outstanding !== 3'd4) begin
            n_fail++; $display("FAIL b2b_limit: got pop=%0b ready=%0b out=%0d want 0 0 4", pop, cmd_ready, outstanding); end
        l0_pop = 1'b1; pop_tid = 2'd1; pop_data = 16'h0033;
        tick();
        l0_pop = 1'b0;
        #1;
        n_cmp++; if (pop !== 1'b1 || outstanding !== 3'd3) begin n_fail++; $display("FAIL b2b_fifth: got pop=%0b out=%0d want 1 3", pop, outstanding); end
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h0033 || rsp_tid !== 2'd1) begin
            n_fail++; $display("FAIL b2b_rsp: got v=%0b d=%h t=%0h want 1 0033 1", rsp_valid, rsp_data, rsp_tid); end
        tick();
        n_cmp++; if (outstanding !== 3'd4 || pop !== 1'b0) begin n_fail++; $display("FAIL b2b_out4: got out=%0d pop=%0b want 4 0", outstanding, pop); end
        rsp_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            l0_pop = 1'b1; pop_tid = 2'd0; pop_data = 16'h0010 + 16'(j);
            tick();
            #1;
            n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h0010 + 16'(j)) begin
                n_fail++; $display("FAIL fwft_%0d: got v=%0b d=%h want 1 %h", j, rsp_valid, rsp_data, 16'h0010 + 16'(j)); end
        end
        l0_pop = 1'b0;
        tick();
        rsp_ready = 1'b0;
        #1;
        n_cmp++; if (rsp_valid !== 1'b0 || outstanding !== 3'd1) begin n_fail++; $display("FAIL drain_rsp: got v=%0b out=%0d want 0 1", rsp_valid, outstanding); end
    endtask

    task automatic test_empty_spurious();
        l0_pop = 1'b1; pop_tid = 2'd3; pop_data = 16'hFFFF;
        tick();
        l0_pop = 1'b0;
        #1;
        n_cmp++; if (rsp_empty !== 1'b1 || rsp_valid !== 1'b1 || outstanding !== 3'd0) begin
            n_fail++; $display("FAIL empty_rsp: got e=%0b v=%0b out=%0d want 1 1 0", rsp_empty, rsp_valid, outstanding); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_early: got %0b want 0", err); end
        l0_pop = 1'b1; pop_tid = 2'd2; pop_data = 16'h0777;
        tick();
        l0_pop = 1'b0;
        #1;
        n_cmp++; if (err !== 1'b1 || rsp_data !== 16'hFFFF || outstanding !== 3'd0) begin
            n_fail++; $display("FAIL spurious: got err=%0b d=%h out=%0d want 1 ffff 0", err, rsp_data, outstanding); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1;
        n_cmp++; if (rsp_valid !== 1'b0 || err !== 1'b1) begin n_fail++; $display("FAIL spurious_count: got v=%0b err=%0b want 0 1", rsp_valid, err); end
    endtask

    task automatic test_flush();
        tick();
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_tid = 2'd2;
        tick();
        cmd_tid = 2'd3;
        #1;
        n_cmp++; if (pop !== 1'b1 || tree_id !== 2'd2) begin n_fail++; $display("FAIL flush_pop_a: got pop=%0b t=%0h want 1 2", pop, tree_id); end
        tick();
        cmd_valid = 1'b0;
        flush = 1'b1;
        #1;
        n_cmp++; if (pop !== 1'b1 || tree_id !== 2'd3 || cmd_ready !== 1'b0) begin
            n_fail++; $display("FAIL flush_pop_b: got pop=%0b t=%0h ready=%0b want 1 3 0", pop, tree_id, cmd_ready); end
        tick();
        n_cmp++; if (outstanding !== 3'd2 || cmd_ready !== 1'b0 || flush_done !== 1'b0) begin
            n_fail++; $display("FAIL flush_wait: got out=%0d ready=%0b done=%0b want 2 0 0", outstanding, cmd_ready, flush_done); end
        rsp_ready = 1'b1;
        l0_pop = 1'b1; pop_tid = 2'd2; pop_data = 16'h0AAA;
        tick();
        l0_pop = 1'b0;
        #1;
        n_cmp++; if (rsp_data !== 16'h0AAA || flush_done !== 1'b0) begin n_fail++; $display("FAIL flush_r1: got d=%h done=%0b want 0aaa 0", rsp_data, flush_done); end
        l0_pop = 1'b1; pop_tid = 2'd3; pop_data = 16'h0BBB;
        tick();
        l0_pop = 1'b0;
        #1;
        n_cmp++; if (rsp_data !== 16'h0BBB || outstanding !== 3'd0 || flush_done !== 1'b0) begin
            n_fail++; $display("FAIL flush_r2: got d=%h out=%0d done=%0b want 0bbb 0 0", rsp_data, outstanding, flush_done); end
        tick();
        n_cmp++; if (flush_done !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_done: got done=%0b v=%0b want 1 0", flush_done, rsp_valid); end
        tick();
        n_cmp++; if (flush_done !== 1'b1) begin n_fail++; $display("FAIL flush_level: got %0b want 1", flush_done); end
        flush = 1'b0;
        rsp_ready = 1'b0;
        #1;
        n_cmp++; if (flush_done !== 1'b0) begin n_fail++; $display("FAIL flush_drop: got %0b want 0", flush_done); end
        tick();
        n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL flush_idle: got ready=%0b want 1", cmd_ready); end
    endtask

    task automatic test_reset_mid();
        tick();
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_tid = 2'd1;
        tick();
        cmd_valid = 1'b0;
        tick();
        l0_pop = 1'b1; pop_tid = 2'd1; pop_data = 16'h0055;
        tick();
        l0_pop = 1'b0;
        full = 1'b1;
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_tid = 2'd2; cmd_data = 16'h0F0F;
        tick();
        cmd_valid = 1'b0;
        #1;
        n_cmp++; if (push !== 1'b0 || rsp_valid !== 1'b1 || push_data !== 16'h0F0F) begin
            n_fail++; $display("FAIL mid_setup: got push=%0b v=%0b d=%h want 0 1 0f0f", push, rsp_valid, push_data); end
        test_reset();
        full = 1'b0;
        tick();
        n_cmp++; if (push !== 1'b0 || rsp_valid !== 1'b0 || outstanding !== 3'd0) begin
            n_fail++; $display("FAIL mid_discard: got push=%0b v=%0b out=%0d want 0 0 0", push, rsp_valid, outstanding); end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_tid = '0; cmd_data = '0;
        flush = 1'b0; full = 1'b0; l0_pop = 1'b0; pop_tid = '0; pop_data = '0; rsp_ready = 1'b0;
        test_reset();
        test_push();
        test_stall();
        test_back_to_back();
        test_empty_spurious();
        test_flush();
        test_reset_mid();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
